// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a synchronous 64-bit SRAM; serves one read or write burst at a time.
// FIXED/INCR bursts, byte strobes, per-beat DECERR/SLVERR, fair AW/AR arbitration.
module axi4_sram_slave #(
   parameter int unsigned MEM_WORDS = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  S_AXI_AWID,
   input  logic [63:0] S_AXI_AWADDR,
   input  logic [7:0]  S_AXI_AWLEN,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic [1:0]  S_AXI_AWBURST,
   input  logic        S_AXI_AWLOCK,
   input  logic [3:0]  S_AXI_AWCACHE,
   input  logic [2:0]  S_AXI_AWPROT,
   input  logic [3:0]  S_AXI_AWQOS,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [63:0] S_AXI_WDATA,
   input  logic [7:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WLAST,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [3:0]  S_AXI_BID,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [3:0]  S_AXI_ARID,
   input  logic [63:0] S_AXI_ARADDR,
   input  logic [7:0]  S_AXI_ARLEN,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic [1:0]  S_AXI_ARBURST,
   input  logic        S_AXI_ARLOCK,
   input  logic [3:0]  S_AXI_ARCACHE,
   input  logic [2:0]  S_AXI_ARPROT,
   input  logic [3:0]  S_AXI_ARQOS,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [3:0]  S_AXI_RID,
   output logic [63:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RLAST,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RD    = 2'd1;
   localparam logic [1:0] ST_WR    = 2'd2;
   localparam logic [1:0] ST_WRESP = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;
   localparam logic [1:0] BURST_FIXED = 2'd0;

   // Response codes are ordered so the numerically larger one is the worse one.
   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [1:0]       state_q, state_d;
   logic             en_q;
   logic             last_w_q;
   logic [3:0]       id_q;
   logic [63:0]      addr_q;
   logic [7:0]       len_q;
   logic [2:0]       size_q;
   logic [1:0]       burst_q;
   logic [8:0]       beat_q;
   logic [1:0]       wresp_q;
   logic             wready_q;
   logic             bvalid_q;
   logic [3:0]       bid_q;
   logic [1:0]       bresp_q;
   logic             rvalid_q;
   logic [63:0]      rdata_q;
   logic [1:0]       rresp_q;
   logic             rlast_q;
   logic [3:0]       rid_q;

   logic [63:0]      mem [MEM_WORDS];

   logic             grant_w, grant_r, idle_en;
   logic             aw_hs, ar_hs, rd_issue, r_hs, w_hs, b_hs;
   logic             last_beat, dec_err, slv_err, mem_we;
   logic [63:0]      step, next_addr, off;
   logic [IDX_W-1:0] idx;
   logic [1:0]       beat_resp, w_beat_resp, wresp_new;
   logic             unused_ok;

   assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS,
                        S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};

   // Arbitration: a lone request wins; on contention the channel not granted last time wins.
   assign grant_w = S_AXI_AWVALID & (~S_AXI_ARVALID | ~last_w_q);
   assign grant_r = S_AXI_ARVALID & (~S_AXI_AWVALID | last_w_q);
   assign idle_en = (state_q == ST_IDLE) & en_q;
   assign aw_hs   = idle_en & grant_w;
   assign ar_hs   = idle_en & grant_r;

   assign last_beat = (beat_q[7:0] == len_q);
   assign rd_issue  = (state_q == ST_RD) & (beat_q <= {1'b0, len_q}) & (~rvalid_q | S_AXI_RREADY);
   assign r_hs      = rvalid_q & S_AXI_RREADY;
   assign w_hs      = wready_q & S_AXI_WVALID;
   assign b_hs      = bvalid_q & S_AXI_BREADY;

   // Beat address generation and decode.
   assign step      = 64'(1) << size_q;
   assign next_addr = (burst_q == BURST_FIXED) ? addr_q : ((addr_q & ~(step - 64'd1)) + step);
   assign off       = addr_q - BASE_ADDR;
   assign idx       = off[IDX_W+2:3];
   assign dec_err   = (addr_q < BASE_ADDR) | ((off >> 3) >= 64'(MEM_WORDS));
   assign slv_err   = (size_q > 3'd3) | burst_q[1];
   assign beat_resp = dec_err ? RESP_DECERR : (slv_err ? RESP_SLVERR : RESP_OKAY);

   assign w_beat_resp = worst(beat_resp, (S_AXI_WLAST != last_beat) ? RESP_SLVERR : RESP_OKAY);
   assign wresp_new   = worst(wresp_q, w_beat_resp);
   assign mem_we      = w_hs & (beat_resp == RESP_OKAY);

   assign S_AXI_AWREADY = aw_hs;
   assign S_AXI_ARREADY = ar_hs;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BID     = bid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RID     = rid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (aw_hs) state_d = ST_WR;
                   else if (ar_hs) state_d = ST_RD;
         ST_RD:    if (r_hs && rlast_q) state_d = ST_IDLE;
         ST_WR:    if (w_hs && last_beat) state_d = ST_WRESP;
         ST_WRESP: if (b_hs) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Burst context and registered channel outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q     <= 1'b0;
         last_w_q <= 1'b1;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         beat_q   <= '0;
         wresp_q  <= RESP_OKAY;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         bid_q    <= '0;
         bresp_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
         rlast_q  <= 1'b0;
         rid_q    <= '0;
      end else begin
         en_q <= 1'b1;
         if (aw_hs || ar_hs) begin
            id_q     <= aw_hs ? S_AXI_AWID    : S_AXI_ARID;
            addr_q   <= aw_hs ? S_AXI_AWADDR  : S_AXI_ARADDR;
            len_q    <= aw_hs ? S_AXI_AWLEN   : S_AXI_ARLEN;
            size_q   <= aw_hs ? S_AXI_AWSIZE  : S_AXI_ARSIZE;
            burst_q  <= aw_hs ? S_AXI_AWBURST : S_AXI_ARBURST;
            beat_q   <= '0;
            wresp_q  <= RESP_OKAY;
            last_w_q <= aw_hs;
            wready_q <= aw_hs;
         end
         if (rd_issue) begin
            addr_q   <= next_addr;
            beat_q   <= beat_q + 9'd1;
            rvalid_q <= 1'b1;
            rdata_q  <= (beat_resp == RESP_OKAY) ? mem[idx] : '0;
            rresp_q  <= beat_resp;
            rlast_q  <= last_beat;
            rid_q    <= id_q;
         end else if (r_hs) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
         end
         if (w_hs) begin
            addr_q  <= next_addr;
            beat_q  <= beat_q + 9'd1;
            wresp_q <= wresp_new;
            if (last_beat) begin
               wready_q <= 1'b0;
               bvalid_q <= 1'b1;
               bresp_q  <= wresp_new;
               bid_q    <= id_q;
            end
         end
         if (b_hs) bvalid_q <= 1'b0;
      end
   end

   // SRAM byte-lane writes; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (S_AXI_WSTRB[b]) mem[idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: expected B/R results are queued at stimulus
// time and compared against what the DUT returns.
module tb_axi4_sram_slave;

   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam int unsigned WORDS = 4096;
   localparam logic [1:0]  FIXED = 2'd0;
   localparam logic [1:0]  INCR  = 2'd1;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bresp_t;

   logic        clk_i, rst_ni;
   logic [3:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
   logic [63:0] S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_RDATA;
   logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN, S_AXI_WSTRB;
   logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
   logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
   logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
   logic [81:0] all_out;

   rbeat_t     exp_r[$], obs_r[$];
   bresp_t     exp_b[$], obs_b[$];
   logic [7:0] exp_g[$], obs_g[$];
   int         checks = 0;
   int         errors = 0;
   logic [63:0] wd[16];
   logic [7:0]  ws[16];

   axi4_sram_slave dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(1'b0),
      .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0), .S_AXI_AWQOS(4'd0),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
      .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(1'b0),
      .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0), .S_AXI_ARQOS(4'd0),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   assign all_out = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
                     S_AXI_ARREADY, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID};

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Drives one write burst (SIZE 3); lat = cycles from last W handshake to BVALID.
   task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int last_at,
                            output int lat, output int nbeats);
      int n;
      lat = -1;
      nbeats = 0;
      @(negedge clk_i);
      S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
      S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
      n = 0; #1;
      while (!S_AXI_AWREADY && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!S_AXI_AWREADY) begin
         checks++; errors++; $display("FAIL aw_timeout: got no AWREADY, expected AWREADY=1");
         S_AXI_AWVALID = 1'b0;
         return;
      end
      @(negedge clk_i);
      S_AXI_AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i];
         S_AXI_WLAST = (i == last_at);
         n = 0; #1;
         while (!S_AXI_WREADY && n < 50) begin @(negedge clk_i); #1; n++; end
         if (!S_AXI_WREADY) begin
            checks++; errors++; $display("FAIL w_timeout: got no WREADY on beat %0d, expected WREADY=1", i);
            break;
         end
         @(negedge clk_i);
         nbeats++;
      end
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      n = 1;
      while (!S_AXI_BVALID && n < 50) begin @(negedge clk_i); n++; end
      if (!S_AXI_BVALID) begin
         checks++; errors++; $display("FAIL b_timeout: got no BVALID, expected BVALID=1");
         return;
      end
      lat = n;
      obs_b.push_back({S_AXI_BID, S_AXI_BRESP});
      S_AXI_BREADY = 1'b1;
      @(negedge clk_i);
      S_AXI_BREADY = 1'b0;
   endtask

   // Drives one read burst with RREADY following pat; collects beats and stall stability.
   task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] pat,
                           output int lat, output int stall_bad);
      int n, k;
      logic done, held_v;
      rbeat_t cur, held;
      lat = -1; stall_bad = 0; done = 1'b0; held_v = 1'b0; held = '0;
      @(negedge clk_i);
      S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
      S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
      n = 0; #1;
      while (!S_AXI_ARREADY && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!S_AXI_ARREADY) begin
         checks++; errors++; $display("FAIL ar_timeout: got no ARREADY, expected ARREADY=1");
         S_AXI_ARVALID = 1'b0;
         return;
      end
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk_i);
         k++;
         S_AXI_ARVALID = 1'b0;
         S_AXI_RREADY = pat[2'(k % 4)];
         cur = {S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
         if (held_v && (!S_AXI_RVALID || cur !== held)) stall_bad++;
         held_v = 1'b0;
         if (S_AXI_RVALID) begin
            if (lat < 0) lat = k;
            if (S_AXI_RREADY) begin
               obs_r.push_back(cur);
               done = S_AXI_RLAST;
            end else begin
               held = cur;
               held_v = 1'b1;
            end
         end
      end
      if (!done) begin
         checks++; errors++; $display("FAIL r_timeout: got no RLAST beat, expected RLAST=1");
      end
      @(negedge clk_i);
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h, expected 0", all_out); end
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle: got %h, expected 0", all_out); end
   endtask

   task automatic test_arbitration();
      int n;
      exp_g.push_back(8'h52); exp_g.push_back(8'h57); exp_g.push_back(8'h52); exp_g.push_back(8'h57);
      @(negedge clk_i);
      S_AXI_AWID = 4'd1; S_AXI_AWADDR = BASE + 64'h400; S_AXI_AWLEN = 8'd0;
      S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = INCR;
      S_AXI_ARID = 4'd2; S_AXI_ARADDR = BASE + 64'h400; S_AXI_ARLEN = 8'd0;
      S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = INCR;
      S_AXI_WDATA = 64'h5555_5555_5555_5555; S_AXI_WSTRB = 8'hFF; S_AXI_WLAST = 1'b1;
      S_AXI_WVALID = 1'b1; S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      n = 0;
      while (obs_g.size() < 4 && n < 100) begin
         #1;
         if (S_AXI_AWREADY && S_AXI_ARREADY) begin
            checks++; errors++; $display("FAIL arb_both_ready: got AWREADY=1 ARREADY=1, expected one");
         end else if (S_AXI_ARREADY) obs_g.push_back(8'h52);
         else if (S_AXI_AWREADY) obs_g.push_back(8'h57);
         @(negedge clk_i);
         n++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      repeat (8) @(negedge clk_i);
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      checks++;
      if (obs_g.size() !== exp_g.size()) begin
         errors++; $display("FAIL arb_count: got %0d grants, expected %0d", obs_g.size(), exp_g.size());
      end
      while (exp_g.size() > 0 && obs_g.size() > 0) begin
         logic [7:0] e, o;
         e = exp_g.pop_front(); o = obs_g.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL arb_grant: got %c, expected %c", o, e); end
      end
      exp_g.delete(); obs_g.delete();
   endtask

   task automatic test_write_read();
      int lat, nb, sb;
      for (int i = 0; i < 4; i++) begin wd[i] = 64'(8'h11 * (i + 1)); ws[i] = 8'hFF; end
      exp_b.push_back({4'd5, 2'd0});
      axi_write(4'd5, BASE, 8'd3, INCR, 3, lat, nb);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wr_b_latency: got %0d, expected 1", lat); end
      checks++;
      if (obs_b.size() !== 1) begin errors++; $display("FAIL wr_b_count: got %0d, expected 1", obs_b.size()); end
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         bresp_t e, o;
         e = exp_b.pop_front(); o = obs_b.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL wr_bresp: got %h, expected %h", o, e); end
      end
      exp_b.delete(); obs_b.delete();
      for (int i = 0; i < 4; i++) exp_r.push_back({4'd9, 64'(8'h11 * (i + 1)), 2'd0, i == 3});
      axi_read(4'd9, BASE, 8'd3, INCR, 4'hF, lat, sb);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rd_first_latency: got %0d, expected 2", lat); end
      checks++;
      if (obs_r.size() !== exp_r.size()) begin
         errors++; $display("FAIL rd_count: got %0d, expected %0d", obs_r.size(), exp_r.size());
      end
      while (exp_r.size() > 0 && obs_r.size() > 0) begin
         rbeat_t e, o;
         e = exp_r.pop_front(); o = obs_r.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL rd_beat: got %h, expected %h", o, e); end
      end
      exp_r.delete(); obs_r.delete();
   endtask

   task automatic test_read_stall();
      int lat, nb, sb;
      for (int i = 0; i < 8; i++) begin wd[i] = {8{8'(i + 1)}}; ws[i] = 8'hFF; end
      exp_b.push_back({4'd1, 2'd0});
      axi_write(4'd1, BASE + 64'h200, 8'd7, INCR, 7, lat, nb);
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         bresp_t e, o;
         e = exp_b.pop_front(); o = obs_b.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL stall_preload_bresp: got %h, expected %h", o, e); end
      end
      exp_b.delete(); obs_b.delete();
      for (int i = 0; i < 8; i++) exp_r.push_back({4'd2, {8{8'(i + 1)}}, 2'd0, i == 7});
      axi_read(4'd2, BASE + 64'h200, 8'd7, INCR, 4'b1001, lat, sb);
      checks++;
      if (sb !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable stalls, expected 0", sb); end
      checks++;
      if (obs_r.size() !== exp_r.size()) begin
         errors++; $display("FAIL stall_count: got %0d, expected %0d", obs_r.size(), exp_r.size());
      end
      while (exp_r.size() > 0 && obs_r.size() > 0) begin
         rbeat_t e, o;
         e = exp_r.pop_front(); o = obs_r.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL stall_beat: got %h, expected %h", o, e); end
      end
      exp_r.delete(); obs_r.delete();
   endtask

   task automatic test_boundary();
      int lat, nb, sb;
      logic [63:0] top;
      top = BASE + 64'(WORDS) * 64'd8 - 64'd8;
      wd[0] = 64'hDEAD_BEEF_0123_4567; ws[0] = 8'hFF;
      exp_b.push_back({4'd3, 2'd0});
      axi_write(4'd3, top, 8'd0, INCR, 0, lat, nb);
      exp_r.push_back({4'd3, 64'hDEAD_BEEF_0123_4567, 2'd0, 1'b0});
      exp_r.push_back({4'd3, 64'd0, 2'd3, 1'b1});
      axi_read(4'd3, top, 8'd1, INCR, 4'hF, lat, sb);
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         bresp_t e, o;
         e = exp_b.pop_front(); o = obs_b.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL bound_preload_bresp: got %h, expected %h", o, e); end
      end
      exp_b.delete(); obs_b.delete();
      checks++;
      if (obs_r.size() !== exp_r.size()) begin
         errors++; $display("FAIL bound_count: got %0d, expected %0d", obs_r.size(), exp_r.size());
      end
      while (exp_r.size() > 0 && obs_r.size() > 0) begin
         rbeat_t e, o;
         e = exp_r.pop_front(); o = obs_r.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL bound_beat: got %h, expected %h", o, e); end
      end
      exp_r.delete(); obs_r.delete();
   endtask

   task automatic test_strobe();
      int lat, nb, sb;
      wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'hFF;
      exp_b.push_back({4'd4, 2'd0});
      axi_write(4'd4, BASE + 64'h100, 8'd0, INCR, 0, lat, nb);
      wd[0] = 64'h1111_1111_1111_1111; ws[0] = 8'h0F;
      wd[1] = 64'h2222_2222_2222_2222; ws[1] = 8'hF0;
      exp_b.push_back({4'd6, 2'd0});
      axi_write(4'd6, BASE + 64'h100, 8'd1, FIXED, 1, lat, nb);
      exp_r.push_back({4'd8, 64'h2222_2222_1111_1111, 2'd0, 1'b1});
      axi_read(4'd8, BASE + 64'h100, 8'd0, INCR, 4'hF, lat, sb);
      checks++;
      if (obs_b.size() !== exp_b.size()) begin
         errors++; $display("FAIL strb_b_count: got %0d, expected %0d", obs_b.size(), exp_b.size());
      end
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         bresp_t e, o;
         e = exp_b.pop_front(); o = obs_b.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL strb_bresp: got %h, expected %h", o, e); end
      end
      exp_b.delete(); obs_b.delete();
      while (exp_r.size() > 0 && obs_r.size() > 0) begin
         rbeat_t e, o;
         e = exp_r.pop_front(); o = obs_r.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL strb_word: got %h, expected %h", o, e); end
      end
      exp_r.delete(); obs_r.delete();
   endtask

   task automatic test_wlast_err();
      int lat, nb;
      for (int i = 0; i < 3; i++) begin wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i); ws[i] = 8'hFF; end
      exp_b.push_back({4'd7, 2'd2});
      axi_write(4'd7, BASE + 64'h300, 8'd2, INCR, 1, lat, nb);
      checks++;
      if (nb !== 3) begin errors++; $display("FAIL wlast_beats: got %0d accepted, expected 3", nb); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wlast_b_latency: got %0d, expected 1", lat); end
      while (exp_b.size() > 0 && obs_b.size() > 0) begin
         bresp_t e, o;
         e = exp_b.pop_front(); o = obs_b.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL wlast_bresp: got %h, expected %h", o, e); end
      end
      exp_b.delete(); obs_b.delete();
   endtask

   task automatic test_reset_mid_burst();
      int n, lat, sb;
      logic pre_valid;
      @(negedge clk_i);
      S_AXI_ARID = 4'd4; S_AXI_ARADDR = BASE + 64'h200; S_AXI_ARLEN = 8'd7;
      S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = INCR; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      n = 0; #1;
      while (!S_AXI_ARREADY && n < 50) begin @(negedge clk_i); #1; n++; end
      if (!S_AXI_ARREADY) begin
         checks++; errors++; $display("FAIL rst_ar_timeout: got no ARREADY, expected ARREADY=1");
      end
      @(negedge clk_i); S_AXI_ARVALID = 1'b0;
      @(negedge clk_i);
      pre_valid = S_AXI_RVALID;
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if (pre_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_rvalid: got %b, expected 1", pre_valid); end
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL rst_async_outputs: got %h, expected 0", all_out); end
      @(negedge clk_i); S_AXI_RREADY = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL rst_release_idle: got %h, expected 0", all_out); end
      for (int i = 0; i < 4; i++) exp_r.push_back({4'd9, 64'(8'h11 * (i + 1)), 2'd0, i == 3});
      axi_read(4'd9, BASE, 8'd3, INCR, 4'hF, lat, sb);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL rst_rd_latency: got %0d, expected 2", lat); end
      checks++;
      if (obs_r.size() !== exp_r.size()) begin
         errors++; $display("FAIL rst_rd_count: got %0d, expected %0d", obs_r.size(), exp_r.size());
      end
      while (exp_r.size() > 0 && obs_r.size() > 0) begin
         rbeat_t e, o;
         e = exp_r.pop_front(); o = obs_r.pop_front();
         checks++;
         if (o !== e) begin errors++; $display("FAIL rst_rd_beat: got %h, expected %h", o, e); end
      end
      exp_r.delete(); obs_r.delete();
   endtask

   initial begin
      rst_ni = 1'b0;
      S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0;
      S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0;
      S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0;
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = '0; end
      test_reset();
      test_arbitration();
      test_write_read();
      test_read_stall();
      test_boundary();
      test_strobe();
      test_wlast_err();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 slave (responder) backed by an on-chip synchronous SRAM of 64-bit words.
- Terminates the core's 64-bit AXI4 master port on FPGA builds, serving as boot/scratch memory for bring-up and simulation.
- Handles one transaction at a time: either one read burst or one write burst.
- Supports FIXED and INCR bursts, byte strobes and narrow transfers.

Parameters:
- MEM_WORDS, 4096, number of 64-bit words; power of two.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.

Ports:
- clk_i input 1: clock.
- rst_ni input 1: reset.
- S_AXI_AWID input 4, S_AXI_AWADDR input 64, S_AXI_AWLEN input 8, S_AXI_AWSIZE input 3, S_AXI_AWBURST input 2: write address channel.
- S_AXI_AWLOCK input 1, S_AXI_AWCACHE input 4, S_AXI_AWPROT input 3, S_AXI_AWQOS input 4: ignored.
- S_AXI_AWVALID input 1, S_AXI_AWREADY output 1: write address handshake.
- S_AXI_WDATA input 64, S_AXI_WSTRB input 8, S_AXI_WLAST input 1, S_AXI_WVALID input 1, S_AXI_WREADY output 1: write data channel.
- S_AXI_BID output 4, S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1: write response channel.
- S_AXI_ARID input 4, S_AXI_ARADDR input 64, S_AXI_ARLEN input 8, S_AXI_ARSIZE input 3, S_AXI_ARBURST input 2: read address channel.
- S_AXI_ARLOCK input 1, S_AXI_ARCACHE input 4, S_AXI_ARPROT input 3, S_AXI_ARQOS input 4: ignored.
- S_AXI_ARVALID input 1, S_AXI_ARREADY output 1: read address handshake.
- S_AXI_RID output 4, S_AXI_RDATA output 64, S_AXI_RRESP output 2, S_AXI_RLAST output 1, S_AXI_RVALID output 1, S_AXI_RREADY input 1: read data channel.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- In reset, all outputs are 0, state is IDLE, and the arbiter's last-grant register is WRITE. SRAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately; no response is issued for it.
- States: IDLE, RD, WR, WRESP.
- IDLE:
  - AWREADY = AWVALID & grant_w; ARREADY = ARVALID & grant_r.
  - When only one of AWVALID/ARVALID is high, that channel is granted.
  - When both are high, the channel not granted last time wins.
  - A handshake latches ID, address, LEN, SIZE and BURST, updates last-grant, and moves to RD or WR.
  - AWREADY and ARREADY are 0 outside IDLE.
- Beat address:
  - beat 0 = AxADDR.
  - INCR: next = (addr & ~((1<<SIZE)-1)) + (1<<SIZE).
  - FIXED: address constant.
  - Word index = (addr - BASE_ADDR) >> 3.
  - No 4 KB boundary check.
- Per-beat response:
  - DECERR if addr < BASE_ADDR or index >= MEM_WORDS.
  - SLVERR if SIZE > 3 or BURST is WRAP (2) or reserved (3).
  - Otherwise OKAY. EXOKAY is never returned; exclusive access gets OKAY.
- RD:
  - An SRAM read is issued when beats remain and (!RVALID | RREADY).
  - RDATA comes from the SRAM output register; RVALID rises the cycle after issue.
  - AR handshake at cycle T gives first RVALID at T+2.
  - Full throughput: 1 beat/cycle while RREADY is held high.
  - RDATA, RRESP, RLAST and RID stay stable while RVALID & !RREADY.
  - RLAST is high on beat LEN. Error beats return RDATA = 0.
  - The last beat's handshake moves to IDLE in the same edge.
- WR:
  - WREADY = 1 from T+1 (T = AW handshake) until beat LEN has been accepted.
  - Each W handshake on an OKAY beat writes the SRAM bytes whose WSTRB bit is 1, in that cycle. Error beats write nothing.
  - Beat count, not WLAST, terminates the burst.
  - WLAST high on an earlier beat, or low on beat LEN, records SLVERR.
- WRESP:
  - Entered after the final W handshake at cycle U; BVALID = 1 from U+1 until the BREADY handshake, then IDLE.
  - BRESP = worst of all beats (DECERR > SLVERR > OKAY). BID = latched AWID.
- Reads and writes to the same word in consecutive transactions return the newest data; no bypass is needed because transactions are serialized.

Test Plan:
- Write AW addr 0x8000_0000, LEN 3, SIZE 3, INCR, ID 5, data 0x11..0x44, WSTRB 0xFF → BVALID 1 cycle after the last W, BID 5, BRESP OKAY. Read the same region with ID 9 → 4 beats 0x11, 0x22, 0x33, 0x44, first RVALID at T+2, RLAST on beat 3, RRESP OKAY.
- Read LEN 7 with RREADY toggled 1,0,0,1,... → RDATA held during stalls, 8 beats in order, no beat lost or duplicated.
- AWVALID and ARVALID both high from reset, repeatedly → grants alternate R, W, R, W.
- Read at BASE_ADDR + MEM_WORDS*8 - 8, LEN 1, INCR → beat 0 OKAY with data, beat 1 DECERR with data 0.
- Write LEN 1 with WSTRB 0x0F then 0xF0 over a word preloaded to 0xAAAA_AAAA_AAAA_AAAA, FIXED, data 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222 → word reads 0x2222_2222_1111_1111.
- Write LEN 2 with WLAST on beat 1 → 3 beats accepted, BRESP SLVERR. Then assert rst_ni low mid-read burst → all outputs 0 asynchronously, next transaction after reset behaves normally.
